// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the instruction-fetch front end.
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   EBREAK_INSTR  : encoding that halts fetch once latched
//   if_id_t       : contents of the IF/ID pipeline register
//   fetch_state_t : fetch controller state
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load and bubble controls.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   i_load     : capture {i_pc, i_pc+4, i_instr, valid=1}
//   i_bubble   : replace instr/valid with a bubble, pc/pc4 keep their value
//   i_pc       : PC of the word being captured
//   i_instr    : instruction word being captured
//   o_pc/o_pc4/o_instr/o_valid : register contents
// Neither control asserted means hold. Bubble takes precedence over load.
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr,
    output logic        o_valid
);
    import pipeline_pkg::*;

    if_id_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q.pc    <= 32'h0000_0000;
            r_q.pc4   <= 32'h0000_0000;
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (i_bubble) begin
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (i_load) begin
            r_q.pc    <= i_pc;
            r_q.pc4   <= i_pc + PC_STEP;
            r_q.instr <= i_instr;
            r_q.valid <= 1'b1;
        end
    end

    assign o_pc    = r_q.pc;
    assign o_pc4   = r_q.pc4;
    assign o_instr = r_q.instr;
    assign o_valid = r_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, RUN/HALTED controller, fetch counter and
// the IF/ID register (if_id_reg).
//   CLK          : clock, rising edge
//   RESET_N      : asynchronous active-low reset
//   iaddr        : ROM byte address, equal to the PC register
//   idata        : ROM word for iaddr, same cycle
//   stall        : hold PC, IF/ID and counter
//   flush        : bubble into IF/ID
//   redirect     : taken branch/jump from EX, highest priority
//   redirect_pc  : redirect target (low two bits ignored)
//   if_id_*      : IF/ID register contents
//   halted       : fetch stopped after latching EBREAK
//   fetch_count  : number of valid words latched into IF/ID
// Cycle priority: redirect > flush > stall > normal advance.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    // Reset value of fetch_count; nonzero only to bring up the wrap path.
    parameter logic [31:0] COUNT_PRESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);
    import pipeline_pkg::*;

    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;
    logic         r_halted;
    fetch_state_t r_state;

    logic [31:0]  w_pc4;
    logic [31:0]  w_target;
    logic         w_advance;
    logic         w_bubble;
    logic         w_is_ebreak;
    logic         w_unused_low_bits;

    assign w_pc4       = r_pc + PC_STEP;
    assign w_target    = {redirect_pc[31:2], 2'b00};
    assign w_is_ebreak = (idata == EBREAK_INSTR);
    // Target is forced word-aligned, so its low bits carry no information.
    assign w_unused_low_bits = ^redirect_pc[1:0];

    // A real instruction is captured only when nothing else claims the cycle.
    assign w_advance = !redirect && !flush && !stall && (r_state == RUN);
    // While halted, every non-stalled cycle drops a bubble into IF/ID.
    assign w_bubble  = redirect || flush || (!stall && (r_state == HALTED));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc          <= RESET_PC;
            r_state       <= RUN;
            r_halted      <= 1'b0;
            r_fetch_count <= COUNT_PRESET;
        end else if (redirect) begin
            // Redirect also recovers from a wrong-path EBREAK halt.
            r_pc     <= w_target;
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush) begin
                        if (!stall) begin
                            r_pc <= w_pc4;
                        end
                    end else if (!stall) begin
                        r_pc          <= w_pc4;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        if (w_is_ebreak) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .i_load   (w_advance),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_instr  (idata),
        .o_pc     (if_id_pc),
        .o_pc4    (if_id_pc4),
        .o_instr  (if_id_instr),
        .o_valid  (if_id_valid)
    );

    assign iaddr       = r_pc;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed stimulus for fetch_stage with a behavioural reference model and
// per-cycle output comparison, plus literal checks at key points.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] w_iaddr;
    logic [31:0] w_idata;
    logic [31:0] unused_w_pc;
    logic [31:0] unused_w_pc4;
    logic [31:0] unused_w_instr;
    logic        unused_w_valid;
    logic        unused_w_halted;
    logic [31:0] w_fetch_count;

    logic [31:0] rom [0:1023];

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
    logic        m_valid, m_halt;

    assign idata   = rom[iaddr[11:2]];
    assign w_idata = rom[w_iaddr[11:2]];

    fetch_stage dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .iaddr       (iaddr),
        .idata       (idata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    fetch_stage #(.COUNT_PRESET(32'hFFFF_FFFF)) u_wrap (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .iaddr       (w_iaddr),
        .idata       (w_idata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (unused_w_pc),
        .if_id_pc4   (unused_w_pc4),
        .if_id_instr (unused_w_instr),
        .if_id_valid (unused_w_valid),
        .halted      (unused_w_halted),
        .fetch_count (w_fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: outputs derived directly from the fetch rules.
    always @(posedge CLK or negedge RESET_N) begin
        logic [31:0] word;
        if (!RESET_N) begin
            m_pc = 32'h0; m_halt = 1'b0; m_cnt = 32'h0;
            m_instr = NOP; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end else if (flush) begin
            m_instr = NOP; m_valid = 1'b0;
            if (!stall && !m_halt) m_pc = m_pc + 32'd4;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_halt) begin
            m_instr = NOP; m_valid = 1'b0;
        end else begin
            word    = rom[m_pc[11:2]];
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = word;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
            if (word == EBREAK) m_halt = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("iaddr",       iaddr,              m_pc);
            chk("if_id_pc",    if_id_pc,           m_ipc);
            chk("if_id_pc4",   if_id_pc4,          m_ipc4);
            chk("if_id_instr", if_id_instr,        m_instr);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            chk("halted",      {31'b0, halted},    {31'b0, m_halt});
            chk("fetch_count", fetch_count,        m_cnt);
        end
    end

    // Apply one cycle of controls, return 1 time unit after the edge.
    task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = NOP;
        rom[0]    = 32'h0050_0093;
        rom[1]    = 32'h0060_0113;
        rom[2]    = 32'h0070_0193;
        rom[3]    = 32'h0080_0213;
        rom[4]    = EBREAK;
        rom[8]    = 32'h00B0_0393;
        rom[9]    = 32'h00C0_0413;
        rom[16]   = 32'h00A0_0313;
        rom[1023] = 32'h0090_0293;

        RESET_N = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_wrap_count", w_fetch_count, 32'hFFFF_FFFF);
        cmp_en = 1;

        // Reset release, two sequential fetches
        RESET_N = 1'b1;
        cyc(0, 0, 0, 0);
        chk("c1_pc", if_id_pc, 32'h0);
        chk("c1_instr", if_id_instr, 32'h0050_0093);
        chk("c1_valid", {31'b0, if_id_valid}, 32'h1);
        chk("wrap_count", w_fetch_count, 32'h0);
        cyc(0, 0, 0, 0);
        chk("c2_pc", if_id_pc, 32'h4);
        chk("c2_instr", if_id_instr, 32'h0060_0113);
        chk("c2_count", fetch_count, 32'h2);

        // Stall two cycles at pc=0x8
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("stall_iaddr", iaddr, 32'h8);
        chk("stall_pc", if_id_pc, 32'h4);
        chk("stall_count", fetch_count, 32'h2);
        cyc(0, 0, 0, 0);
        chk("resume_pc", if_id_pc, 32'h8);

        // Run into EBREAK at 0x10
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("ebreak_instr", if_id_instr, EBREAK);
        chk("ebreak_valid", {31'b0, if_id_valid}, 32'h1);
        chk("ebreak_halted", {31'b0, halted}, 32'h1);
        chk("ebreak_iaddr", iaddr, 32'h14);
        chk("ebreak_count", fetch_count, 32'h5);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("halt_bubble", {31'b0, if_id_valid}, 32'h0);
        chk("halt_iaddr", iaddr, 32'h14);

        // Redirect out of HALTED
        cyc(0, 0, 1, 32'h20);
        chk("unhalt", {31'b0, halted}, 32'h0);
        chk("unhalt_iaddr", iaddr, 32'h20);
        cyc(0, 0, 0, 0);
        chk("unhalt_fetch", if_id_instr, 32'h00B0_0393);
        cyc(0, 0, 0, 0);

        // Redirect with stall and misaligned target
        cyc(1, 0, 1, 32'h43);
        chk("rd_iaddr", iaddr, 32'h40);
        chk("rd_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rd_instr", if_id_instr, NOP);
        cyc(0, 0, 0, 0);
        chk("rd_next_pc", if_id_pc, 32'h40);

        // Flush alone, then flush with stall
        cyc(0, 1, 0, 0);
        chk("flush_iaddr", iaddr, 32'h48);
        cyc(1, 1, 0, 0);
        chk("flush_stall_iaddr", iaddr, 32'h48);
        cyc(0, 0, 0, 0);

        // PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFFD);
        chk("wrap_pre", iaddr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("wrap_iaddr", iaddr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // Back to EBREAK, then flush while halted
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("halt2", {31'b0, halted}, 32'h1);
        cyc(0, 1, 0, 0);
        chk("halt_flush_iaddr", iaddr, 32'h14);

        // Asynchronous reset mid-cycle while halted
        cyc(0, 0, 0, 0);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_halted", {31'b0, halted}, 32'h0);
        chk("async_iaddr", iaddr, 32'h0);
        chk("async_count", fetch_count, 32'h0);
        chk("async_valid", {31'b0, if_id_valid}, 32'h0);
        chk("async_instr", if_id_instr, NOP);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        cyc(0, 0, 0, 0);
        chk("restart_pc", if_id_pc, 32'h0);
        chk("restart_instr", if_id_instr, 32'h0050_0093);
        chk("restart_count", fetch_count, 32'h1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
